fetch_ctrl_unit: RTL and testbench

Control end of the fetch interface. It consumes the instruction word and instruction_number produced by the fetch stage and decodes control-flow opcodes. It drives the fetch stage's redirect inputs (branch_ctrl, jump_ctrl, branch_val, jump_val) and lifecycle inputs (init_ctrl, done_ctrl). It squashes the one wrong-path instruction after each redirect and counts retired instructions.

---
 rtl/fetch_ctrl_pkg.sv | 37 +++
 rtl/fetch_ctrl_if.sv | 30 +++
 rtl/fetch_ctrl_unit.sv | 132 +++++++++++++
 tb/tb_fetch_ctrl_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch control unit.
// Opcodes, FSM state encoding and the control-flow decoder.
package fetch_ctrl_pkg;

   localparam int OPC_W = 4;

   localparam logic [OPC_W-1:0] OP_HALT = 4'hD;
   localparam logic [OPC_W-1:0] OP_BR   = 4'hE;
   localparam logic [OPC_W-1:0] OP_JMP  = 4'hF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      RUN   = 2'd2,
      HALT  = 2'd3
   } state_t;

   typedef struct packed {
      logic take_br;
      logic take_jmp;
      logic halt;
   } dec_t;

   function automatic dec_t decode(
      input logic [OPC_W-1:0] opc,
      input logic [4:0]       low,
      input logic             cond
   );
      dec_t d;
      d          = '0;
      d.take_br  = (opc == OP_BR) && cond;
      d.take_jmp = (opc == OP_JMP);
      d.halt     = (opc == OP_HALT) && (low == 5'd0);
      return d;
   endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch <-> control bundle: instruction in, redirect and
// lifecycle controls out.
interface fetch_ctrl_if #(
   parameter int INSTR_W = 9,
   parameter int PC_W    = 8
);
   logic [INSTR_W-1:0] instr;
   logic [PC_W-1:0]    instruction_number;
   logic               cond_flag;
   logic [PC_W-1:0]    reg_branch_val;
   logic               branch_ctrl;
   logic [PC_W-1:0]    branch_val;
   logic               jump_ctrl;
   logic [PC_W-1:0]    jump_val;
   logic               init_ctrl;
   logic               done_ctrl;
   logic               squash;

   modport master (
      input  instr, instruction_number, cond_flag, reg_branch_val,
      output branch_ctrl, branch_val, jump_ctrl, jump_val,
      output init_ctrl, done_ctrl, squash
   );

   modport slave (
      output instr, instruction_number, cond_flag, reg_branch_val,
      input  branch_ctrl, branch_val, jump_ctrl, jump_val,
      input  init_ctrl, done_ctrl, squash
   );
endinterface

// File: rtl/fetch_ctrl_unit.sv
// Control end of fetch: decodes control-flow opcodes, drives
// redirects, squashes the wrong-path slot, counts retirements.
module fetch_ctrl_unit
   import fetch_ctrl_pkg::*;
#(
   parameter int INSTR_W = 9,
   parameter int PC_W    = 8,
   parameter int CNT_W   = 17
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   fetch_ctrl_if.master     bus,
   output logic [CNT_W-1:0] retired,
   output logic [1:0]       state_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic              br_q, br_d;
   logic              jmp_q, jmp_d;
   logic              done_q, done_d;
   logic              init_q, init_d;
   logic              sq_q, sq_d;
   logic [PC_W-1:0]   bval_q, bval_d;
   logic [PC_W-1:0]   jval_q, jval_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic              clr, inc;
   logic [OPC_W-1:0]  opc;
   logic [4:0]        low;
   dec_t              dec;
   logic              unused_pc;

   assign opc       = bus.instr[INSTR_W-1 -: OPC_W];
   assign low       = bus.instr[4:0];
   assign dec       = decode(opc, low, bus.cond_flag);
   assign unused_pc = ^bus.instruction_number;

   // Next state, next registered controls and counter update.
   always_comb begin
      state_d = state_q;
      br_d    = 1'b0;
      jmp_d   = 1'b0;
      done_d  = 1'b0;
      init_d  = 1'b0;
      sq_d    = 1'b0;
      bval_d  = bval_q;
      jval_d  = jval_q;
      clr     = 1'b0;
      inc     = 1'b0;
      unique case (state_q)
         IDLE: begin
            init_d = 1'b1;
            if (start) begin
               clr     = 1'b1;
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            sq_d    = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            inc = 1'b1;
            if (dec.take_br) begin
               br_d    = 1'b1;
               bval_d  = bus.reg_branch_val;
               state_d = FLUSH;
            end else if (dec.take_jmp) begin
               jmp_d   = 1'b1;
               jval_d  = PC_W'({low, 3'b000});
               state_d = FLUSH;
            end else if (dec.halt) begin
               done_d  = 1'b1;
               state_d = HALT;
            end
         end
         HALT: begin
            if (start) begin
               init_d  = 1'b1;
               clr     = 1'b1;
               state_d = FLUSH;
            end
         end
         default: state_d = IDLE;
      endcase
      if (clr)
         retired_d = '0;
      else if (inc && retired_q != CNT_MAX)
         retired_d = retired_q + CNT_ONE;
      else
         retired_d = retired_q;
   end

   // State and registered outputs; reset aborts any pending redirect.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         br_q      <= 1'b0;
         jmp_q     <= 1'b0;
         done_q    <= 1'b0;
         init_q    <= 1'b1;
         sq_q      <= 1'b0;
         bval_q    <= '0;
         jval_q    <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         br_q      <= br_d;
         jmp_q     <= jmp_d;
         done_q    <= done_d;
         init_q    <= init_d;
         sq_q      <= sq_d;
         bval_q    <= bval_d;
         jval_q    <= jval_d;
         retired_q <= retired_d;
      end
   end

   assign bus.branch_ctrl = br_q;
   assign bus.branch_val  = bval_q;
   assign bus.jump_ctrl   = jmp_q;
   assign bus.jump_val    = jval_q;
   assign bus.init_ctrl   = init_q;
   assign bus.done_ctrl   = done_q;
   assign bus.squash      = sq_q;
   assign retired         = retired_q;
   assign state_o         = state_q;

endmodule

// File: tb/tb_fetch_ctrl_unit.sv
// Bench for fetch_ctrl_unit: vector table plus a saturation
// sequence, expected outputs queued at drive time.
module tb_fetch_ctrl_unit;

   typedef struct packed {
      logic [1:0]  st;
      logic        br;
      logic [7:0]  bv;
      logic        jmp;
      logic [7:0]  jv;
      logic        init;
      logic        done;
      logic        sq;
      logic [16:0] ret;
   } out_t;

   typedef struct {
      logic       rst_n;
      logic       start;
      logic [8:0] instr;
      logic       cond;
      logic [7:0] rbv;
      out_t       exp;
   } vec_t;

   localparam logic [8:0] NOP  = 9'h000;
   localparam logic [8:0] BR   = 9'h1C0;
   localparam logic [8:0] JMP3 = 9'h1E3;
   localparam logic [8:0] HLT  = 9'h1A0;
   localparam logic [8:0] HLTX = 9'h1A1;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [16:0] retired;
   logic [1:0]  state_o;

   fetch_ctrl_if #(.INSTR_W(9), .PC_W(8)) bus();

   fetch_ctrl_unit #(.INSTR_W(9), .PC_W(8), .CNT_W(17)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .bus     (bus.master),
      .retired (retired),
      .state_o (state_o)
   );

   always #5 clock = ~clock;

   int   checks = 0;
   int   errors = 0;
   out_t sb[$];
   vec_t tv[19];

   function automatic out_t o(
      input logic [1:0] st, input logic br, input logic [7:0] bv,
      input logic jmp, input logic [7:0] jv, input logic init,
      input logic done, input logic sq, input logic [16:0] ret
   );
      out_t r;
      r = '{st, br, bv, jmp, jv, init, done, sq, ret};
      return r;
   endfunction

   function automatic vec_t v(
      input logic rst_n, input logic st, input logic [8:0] ins,
      input logic cond, input logic [7:0] rbv, input out_t e
   );
      vec_t r;
      r.rst_n = rst_n;
      r.start = st;
      r.instr = ins;
      r.cond  = cond;
      r.rbv   = rbv;
      r.exp   = e;
      return r;
   endfunction

   function automatic out_t sample();
      out_t r;
      r = '{state_o, bus.branch_ctrl, bus.branch_val, bus.jump_ctrl,
            bus.jump_val, bus.init_ctrl, bus.done_ctrl, bus.squash,
            retired};
      return r;
   endfunction

   task automatic drive(input vec_t x);
      reset_n                = x.rst_n;
      start                  = x.start;
      bus.instr              = x.instr;
      bus.cond_flag          = x.cond;
      bus.reg_branch_val     = x.rbv;
      bus.instruction_number = 8'($urandom);
      sb.push_back(x.exp);
   endtask

   task automatic check(input string name);
      out_t e, g;
      g = sample();
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard empty, got %h", name, g);
      end else begin
         e = sb.pop_front();
         if (g !== e) begin
            errors++;
            $display({"FAIL %s got st=%0d br=%b bv=%h jmp=%b jv=%h ",
                      "init=%b done=%b sq=%b ret=%h | exp st=%0d br=%b ",
                      "bv=%h jmp=%b jv=%h init=%b done=%b sq=%b ret=%h"},
                     name, g.st, g.br, g.bv, g.jmp, g.jv, g.init,
                     g.done, g.sq, g.ret, e.st, e.br, e.bv, e.jmp,
                     e.jv, e.init, e.done, e.sq, e.ret);
         end
      end
   endtask

   task automatic step(input vec_t x, input string name);
      drive(x);
      @(posedge clock);
      @(negedge clock);
      check(name);
   endtask

   initial begin
      tv[0]  = v(0, 0, NOP,  0, 8'h00, o(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0));
      tv[1]  = v(1, 0, NOP,  0, 8'h00, o(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0));
      tv[2]  = v(1, 1, NOP,  0, 8'h00, o(1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0));
      tv[3]  = v(1, 1, JMP3, 0, 8'h00, o(2, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0));
      tv[4]  = v(1, 0, NOP,  0, 8'h00, o(2, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1));
      tv[5]  = v(1, 0, BR,   0, 8'hFC, o(2, 0, 8'h00, 0, 8'h00, 0, 0, 0, 2));
      tv[6]  = v(1, 0, BR,   1, 8'hFC, o(1, 1, 8'hFC, 0, 8'h00, 0, 0, 0, 3));
      tv[7]  = v(1, 0, NOP,  0, 8'h00, o(2, 0, 8'hFC, 0, 8'h00, 0, 0, 1, 3));
      tv[8]  = v(1, 0, JMP3, 0, 8'h00, o(1, 0, 8'hFC, 1, 8'h18, 0, 0, 0, 4));
      tv[9]  = v(1, 0, NOP,  0, 8'h00, o(2, 0, 8'hFC, 0, 8'h18, 0, 0, 1, 4));
      tv[10] = v(1, 0, HLTX, 0, 8'h00, o(2, 0, 8'hFC, 0, 8'h18, 0, 0, 0, 5));
      tv[11] = v(1, 0, HLT,  0, 8'h00, o(3, 0, 8'hFC, 0, 8'h18, 0, 1, 0, 6));
      tv[12] = v(1, 0, NOP,  0, 8'h00, o(3, 0, 8'hFC, 0, 8'h18, 0, 0, 0, 6));
      tv[13] = v(1, 0, BR,   1, 8'h10, o(3, 0, 8'hFC, 0, 8'h18, 0, 0, 0, 6));
      tv[14] = v(1, 1, NOP,  0, 8'h00, o(1, 0, 8'hFC, 0, 8'h18, 1, 0, 0, 0));
      tv[15] = v(1, 0, NOP,  0, 8'h00, o(2, 0, 8'hFC, 0, 8'h18, 0, 0, 1, 0));
      tv[16] = v(1, 0, BR,   1, 8'h04, o(1, 1, 8'h04, 0, 8'h18, 0, 0, 0, 1));
      tv[17] = v(0, 0, NOP,  0, 8'h00, o(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0));
      tv[18] = v(1, 0, NOP,  0, 8'h00, o(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0));

      for (int i = 0; i < 19; i++)
         step(tv[i], $sformatf("vec%0d", i));

      step(v(1, 1, NOP, 0, 8'h00,
             o(1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0)), "sat_start");
      step(v(1, 0, NOP, 0, 8'h00,
             o(2, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0)), "sat_flush");
      dut.retired_q = 17'h1FFFE;
      for (int k = 0; k < 3; k++)
         step(v(1, 0, NOP, 0, 8'h00,
                o(2, 0, 8'h00, 0, 8'h00, 0, 0, 0, 17'h1FFFF)),
              $sformatf("sat_ret%0d", k));
      step(v(1, 0, HLT, 0, 8'h00,
             o(3, 0, 8'h00, 0, 8'h00, 0, 1, 0, 17'h1FFFF)), "sat_halt");
      step(v(1, 0, NOP, 0, 8'h00,
             o(3, 0, 8'h00, 0, 8'h00, 0, 0, 0, 17'h1FFFF)), "sat_frozen");

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain got %0d left, exp 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
